// File: rtl/cog_vcap_pkg.sv
// cog_vcap_pkg: shared state encoding and cfg/scl field positions for the
// cog video capture block.
package cog_vcap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        DELAY   = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    // cfg bit positions
    localparam int CFG_EN      = 31;
    localparam int CFG_MODE    = 28;
    localparam int CFG_TEN     = 24;
    localparam int CFG_TEDGE   = 23;
    localparam int CFG_TPIN_HI = 22;
    localparam int CFG_TPIN_LO = 18;
    localparam int CFG_SEL_HI  = 4;
    localparam int CFG_SEL_LO  = 0;

    // scl bit positions
    localparam int SCL_CPP_HI  = 19;
    localparam int SCL_CPP_LO  = 12;
    localparam int SCL_DLY_HI  = 11;
    localparam int SCL_DLY_LO  = 0;

    // Clocks per pixel as a counter reload value; a zero field means 256.
    function automatic logic [8:0] cpp_clocks(input logic [19:0] scl);
        logic [7:0] f;
        f = scl[SCL_CPP_HI:SCL_CPP_LO];
        return (f == 8'd0) ? 9'd256 : {1'b0, f};
    endfunction

endpackage

// File: rtl/cog_vcap_sync.sv
// cog_vcap_sync: multi-stage synchronizer bringing the raw pins into the cog
// clock domain. Cleared along with the rest of the block by ena.
module cog_vcap_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_cog,
    input  logic        ena,
    input  logic [31:0] i_d,
    output logic [31:0] o_q
);
    logic [SYNC_STAGES-1:0][31:0] r_stage;

    // Shift the pin vector through SYNC_STAGES flops.
    always_ff @(posedge clk_cog or negedge ena) begin
        if (!ena) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < SYNC_STAGES; i++)
                r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/cog_vcap.sv
// cog_vcap: per-cog video capture. Samples one or two synchronized pins at a
// programmable pixel rate, packs samples LSB-first into longs and hands each
// completed long to the cog through valid/getpix. Optional edge trigger and
// start delay align capture to sync.
module cog_vcap
    import cog_vcap_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_cog,
    input  logic        ena,
    input  logic        setcfg,
    input  logic        setscl,
    input  logic        getpix,
    input  logic [31:0] data,
    input  logic [31:0] pin_in,
    output logic [31:0] pixels,
    output logic        valid,
    output logic        ovr,
    output logic        active
);
    state_t      r_state;
    logic        r_mode, r_tedge, r_trig_prev;
    logic [4:0]  r_tpin, r_sel, r_pcount;
    logic [19:0] r_scl;
    logic [8:0]  r_cnt;
    logic [11:0] r_dcnt;
    logic [31:0] r_sh, r_pixels;
    logic        r_valid, r_ovr;

    logic [31:0] w_ps;
    logic [19:0] w_scl_new;
    logic [4:0]  w_sel_hi;
    logic [31:0] w_shifted;
    logic        w_last, w_tcur, w_trig_hit, w_tick, w_done, w_unused;

    cog_vcap_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_cog (clk_cog),
        .ena     (ena),
        .i_d     (pin_in),
        .o_q     (w_ps)
    );

    // A setscl coinciding with setcfg must be seen by that setcfg.
    assign w_scl_new  = setscl ? data[19:0] : r_scl;
    assign w_sel_hi   = r_sel + 5'd1;
    assign w_shifted  = r_mode ? {w_ps[w_sel_hi], w_ps[r_sel], r_sh[31:2]}
                               : {w_ps[r_sel], r_sh[31:1]};
    assign w_last     = r_mode ? (r_pcount == 5'd15) : (r_pcount == 5'd31);
    assign w_tcur     = w_ps[r_tpin];
    assign w_trig_hit = r_tedge ? (!r_trig_prev && w_tcur) : (r_trig_prev && !w_tcur);
    assign w_tick     = (r_state == CAPTURE) && (r_cnt == 9'd1);
    assign w_done     = w_tick && w_last;
    assign w_unused   = ^{data[30:29], data[27:25]};

    // Control FSM: configuration, trigger, start delay and pixel sampling.
    always_ff @(posedge clk_cog or negedge ena) begin
        if (!ena) begin
            r_state     <= IDLE;
            r_mode      <= 1'b0;
            r_tedge     <= 1'b0;
            r_tpin      <= '0;
            r_sel       <= '0;
            r_scl       <= '0;
            r_cnt       <= '0;
            r_dcnt      <= '0;
            r_pcount    <= '0;
            r_sh        <= '0;
            r_trig_prev <= 1'b0;
        end else begin
            if (setscl)
                r_scl <= data[19:0];
            if (setcfg) begin
                r_mode      <= data[CFG_MODE];
                r_tedge     <= data[CFG_TEDGE];
                r_tpin      <= data[CFG_TPIN_HI:CFG_TPIN_LO];
                r_sel       <= data[CFG_SEL_HI:CFG_SEL_LO];
                r_sh        <= '0;
                r_pcount    <= '0;
                r_trig_prev <= w_ps[data[CFG_TPIN_HI:CFG_TPIN_LO]];
                if (!data[CFG_EN]) begin
                    r_state <= IDLE;
                end else if (data[CFG_TEN]) begin
                    r_state <= ARM;
                end else if (w_scl_new[SCL_DLY_HI:SCL_DLY_LO] != 12'd0) begin
                    r_state <= DELAY;
                    r_dcnt  <= w_scl_new[SCL_DLY_HI:SCL_DLY_LO];
                end else begin
                    r_state <= CAPTURE;
                    r_cnt   <= cpp_clocks(w_scl_new);
                end
            end else begin
                case (r_state)
                    ARM: begin
                        r_trig_prev <= w_tcur;
                        if (w_trig_hit) begin
                            if (r_scl[SCL_DLY_HI:SCL_DLY_LO] != 12'd0) begin
                                r_state <= DELAY;
                                r_dcnt  <= r_scl[SCL_DLY_HI:SCL_DLY_LO];
                            end else begin
                                r_state  <= CAPTURE;
                                r_cnt    <= cpp_clocks(r_scl);
                                r_pcount <= '0;
                            end
                        end
                    end
                    DELAY: begin
                        r_dcnt <= r_dcnt - 12'd1;
                        if (r_dcnt == 12'd1) begin
                            r_state  <= CAPTURE;
                            r_cnt    <= cpp_clocks(r_scl);
                            r_pcount <= '0;
                        end
                    end
                    CAPTURE: begin
                        if (w_tick) begin
                            r_sh     <= w_shifted;
                            r_cnt    <= cpp_clocks(r_scl);
                            r_pcount <= w_last ? 5'd0 : r_pcount + 5'd1;
                        end else begin
                            r_cnt <= r_cnt - 9'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Word handoff: load on free slot or same-cycle consume, else flag overrun.
    always_ff @(posedge clk_cog or negedge ena) begin
        if (!ena) begin
            r_pixels <= '0;
            r_valid  <= 1'b0;
            r_ovr    <= 1'b0;
        end else if (setcfg) begin
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (w_done) begin
            if (!r_valid || getpix) begin
                r_pixels <= w_shifted;
                r_valid  <= 1'b1;
            end else begin
                r_ovr <= 1'b1;
            end
        end else if (getpix) begin
            r_valid <= 1'b0;
        end
    end

    assign pixels = r_pixels;
    assign valid  = r_valid;
    assign ovr    = r_ovr;
    assign active = (r_state == CAPTURE);

endmodule

// File: tb/tb_cog_vcap.sv
// tb_cog_vcap: randomized scoreboard bench for cog_vcap. Pin stimulus is
// planned ahead in pin_seq[]; a reference model derives every expected long
// from the sampling rules and the planned pins.
module tb_cog_vcap;
    localparam int SYNC = 2;

    logic        clk_cog = 1'b0;
    logic        ena = 1'b0, setcfg = 1'b0, setscl = 1'b0;
    logic        mon_get = 1'b0, stim_get = 1'b0;
    logic        getpix;
    logic [31:0] data = '0, pin_in = '0;
    logic [31:0] pixels;
    logic        valid, ovr, active;

    assign getpix = mon_get | stim_get;

    cog_vcap #(.SYNC_STAGES(SYNC)) dut (
        .clk_cog (clk_cog),
        .ena     (ena),
        .setcfg  (setcfg),
        .setscl  (setscl),
        .getpix  (getpix),
        .data    (data),
        .pin_in  (pin_in),
        .pixels  (pixels),
        .valid   (valid),
        .ovr     (ovr),
        .active  (active)
    );

    always #5 clk_cog = ~clk_cog;

    int total = 0, bad = 0, cyc = 0;
    bit mon_en = 1'b0;
    logic [31:0] pin_seq [0:65535];

    typedef struct {
        logic [31:0] word;
        int          edge_n;
    } exp_t;
    exp_t sb[$];

    // cyc = number of the most recent rising edge
    always @(posedge clk_cog) cyc = cyc + 1;

    // pin value present at edge n is pin_seq[n]
    always @(negedge clk_cog) pin_in = pin_seq[16'(cyc + 1)];

    function automatic logic [31:0] pin_at(input int t);
        return pin_seq[16'(t)];
    endfunction

    task automatic pin_set(input int t, input logic [31:0] v);
        pin_seq[16'(t)] = v;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: sample k (1-based) is taken cpp*k clocks after capture entry
    // from the pins as they were SYNC clocks earlier; word j holds samples
    // j*n+1 .. j*n+n, first sample in the lowest bits.
    function automatic logic [31:0] model_word(input int entry, input int cpp,
                                               input bit mode, input int sel, input int j);
        logic [31:0] w, p;
        int n;
        w = '0;
        n = mode ? 16 : 32;
        for (int i = 0; i < n; i++) begin
            p = pin_at(entry + cpp * (j * n + i + 1) - SYNC);
            if (mode) begin
                w[2*i]   = p[sel];
                w[2*i+1] = p[(sel + 1) % 32];
            end else begin
                w[i] = p[sel];
            end
        end
        return w;
    endfunction

    // Monitor: every presented long is consumed and compared with the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_cog);
            mon_get = 1'b0;
            if (mon_en && valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_extra: got %h want no word", pixels);
                end else begin
                    e = sb.pop_front();
                    check("sb_word", pixels, e.word);
                    check("sb_time", 32'(cyc), 32'(e.edge_n));
                end
                mon_get = 1'b1;
            end
        end
    end

    task automatic cfg(input bit sc, input bit ss, input logic [31:0] d, output int e);
        @(negedge clk_cog);
        setcfg = sc;
        setscl = ss;
        data   = d;
        e      = cyc + 1;
        @(negedge clk_cog);
        setcfg = 1'b0;
        setscl = 1'b0;
    endtask

    task automatic wait_empty(input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk_cog);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_timeout: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk_cog);
    endtask

    initial begin
        int e, c, sel, cppv, dly, entry, n, dummy;
        bit mode;
        logic [31:0] d, w0, w2;

        for (int i = 0; i < 65536; i++) pin_seq[i] = '0;

        // reset state
        repeat (2) @(negedge clk_cog);
        check("rst_pixels", pixels, 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_ovr", 32'(ovr), 32'h0);
        check("rst_active", 32'(active), 32'h0);
        ena = 1'b1;
        repeat (3) @(negedge clk_cog);

        // randomized captures, scoreboard checked
        mon_en = 1'b1;
        for (int r = 0; r < 6; r++) begin
            sel  = int'($urandom_range(0, 31));
            mode = 1'($urandom_range(0, 1));
            cppv = int'($urandom_range(1, 6));
            @(negedge clk_cog);
            c = cyc;
            for (int t = c + 2; t < c + 700; t++) pin_set(t, $urandom);
            @(negedge clk_cog);
            d = '0;
            d[31] = 1'b1;
            d[28] = mode;
            d[4:0] = 5'(sel);
            if (r % 2 == 0) begin
                // setscl and setcfg together share the data bus
                d[19:12] = 8'(cppv);
                d[11:5]  = 7'($urandom_range(0, 2));
                dly = int'(d[11:0]);
                cfg(1'b1, 1'b1, d, e);
            end else begin
                dly = int'($urandom_range(0, 3));
                cfg(1'b0, 1'b1, (32'(cppv) << 12) | 32'(dly), dummy);
                cfg(1'b1, 1'b0, d, e);
            end
            entry = e + dly;
            n = mode ? 16 : 32;
            for (int j = 0; j < 2; j++)
                sb.push_back('{model_word(entry, cppv, mode, sel, j), entry + cppv * n * (j + 1)});
            wait_empty(1000);
            cfg(1'b1, 1'b0, 32'h0, dummy);
        end

        // 1bpp alternating pattern, cpp=4, sel=5
        cfg(1'b0, 1'b1, 32'h0000_4000, dummy);
        c = cyc;
        entry = c + 3;
        for (int k = 0; k < 33; k++)
            for (int t = entry + 4 * k - 1; t <= entry + 4 * k + 2; t++)
                pin_set(t, (k & 1) ? 32'h20 : 32'h0);
        @(negedge clk_cog);
        cfg(1'b1, 1'b0, 32'h8000_0005, e);
        check("pat_edge", 32'(e), 32'(entry));
        sb.push_back('{32'hAAAA_AAAA, e + 128});
        wait_empty(300);
        cfg(1'b1, 1'b0, 32'h0, dummy);

        // 2bpp wrap: sel=31 takes pins {0,31}
        cfg(1'b0, 1'b1, 32'h0000_3000, dummy);
        c = cyc;
        for (int t = c + 2; t < c + 200; t++) pin_set(t, 32'h8000_0000);
        @(negedge clk_cog);
        cfg(1'b1, 1'b0, 32'h9000_001F, e);
        sb.push_back('{32'h5555_5555, e + 48});
        wait_empty(200);
        cfg(1'b1, 1'b0, 32'h0, dummy);

        // cpp=0 means 256 clocks per pixel
        cfg(1'b0, 1'b1, 32'h0, dummy);
        sel = int'($urandom_range(0, 31));
        c = cyc;
        for (int t = c + 2; t < c + 8400; t++) pin_set(t, $urandom);
        @(negedge clk_cog);
        cfg(1'b1, 1'b0, 32'h8000_0000 | 32'(sel), e);
        sb.push_back('{model_word(e, 256, 1'b0, sel, 0), e + 8192});
        wait_empty(8400);
        cfg(1'b1, 1'b0, 32'h0, dummy);
        mon_en = 1'b0;

        // overrun, then a consume coincident with a completion
        cfg(1'b0, 1'b1, 32'h0000_2000, dummy);
        c = cyc;
        for (int t = c + 2; t < c + 400; t++) pin_set(t, $urandom);
        @(negedge clk_cog);
        cfg(1'b1, 1'b0, 32'h8000_0003, e);
        w0 = model_word(e, 2, 1'b0, 3, 0);
        w2 = model_word(e, 2, 1'b0, 3, 2);
        wait_cyc(e + 128);
        check("ovr_valid", 32'(valid), 32'h1);
        check("ovr_flag", 32'(ovr), 32'h1);
        check("ovr_hold", pixels, w0);
        wait_cyc(e + 191);
        stim_get = 1'b1;
        @(negedge clk_cog);
        stim_get = 1'b0;
        check("coin_word", pixels, w2);
        check("coin_valid", 32'(valid), 32'h1);
        check("coin_ovr", 32'(ovr), 32'h1);
        cfg(1'b1, 1'b0, 32'h0, dummy);
        check("clr_ovr", 32'(ovr), 32'h0);
        check("clr_valid", 32'(valid), 32'h0);
        check("clr_active", 32'(active), 32'h0);
        check("clr_pixels", pixels, w2);

        // rising-edge trigger on pin 7, delay 10; a lone falling edge is ignored
        cfg(1'b0, 1'b1, 32'h0000_200A, dummy);
        c = cyc;
        for (int t = c + 2; t < c + 20; t++) pin_set(t, 32'h80);
        for (int t = c + 20; t < c + 60; t++) pin_set(t, 32'h0);
        for (int t = c + 60; t < c + 200; t++) pin_set(t, 32'h80);
        repeat (5) @(negedge clk_cog);
        d = '0;
        d[31] = 1'b1;
        d[24] = 1'b1;
        d[23] = 1'b1;
        d[22:18] = 5'd7;
        cfg(1'b1, 1'b0, d, e);
        while (cyc < c + 60) begin
            if ((cyc - c) % 10 == 0) check("trig_idle", 32'(active), 32'h0);
            @(negedge clk_cog);
        end
        wait_cyc(c + 71);
        check("trig_pre", 32'(active), 32'h0);
        @(negedge clk_cog);
        check("trig_on", 32'(active), 32'h1);
        cfg(1'b1, 1'b0, 32'h0, dummy);

        // reset pulse mid-capture
        cfg(1'b0, 1'b1, 32'h0000_1000, dummy);
        c = cyc;
        for (int t = c + 2; t < c + 200; t++) pin_set(t, $urandom | 32'h1);
        @(negedge clk_cog);
        cfg(1'b1, 1'b0, 32'h8000_0000, e);
        wait_cyc(e + 70);
        check("pre_rst_ovr", 32'(ovr), 32'h1);
        ena = 1'b0;
        #1;
        check("arst_pixels", pixels, 32'h0);
        check("arst_valid", 32'(valid), 32'h0);
        check("arst_ovr", 32'(ovr), 32'h0);
        check("arst_active", 32'(active), 32'h0);
        @(negedge clk_cog);
        ena = 1'b1;
        repeat (20) @(negedge clk_cog);
        check("post_pixels", pixels, 32'h0);
        check("post_valid", 32'(valid), 32'h0);
        check("post_active", 32'(active), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cog_vcap.md
Name: cog_vcap

Overview:
- Per-cog video capture block; the receive direction of the cog video generator.
- Samples one or two selected I/O pins at a programmable pixel rate and packs the samples LSB-first into 32-bit longs. This is the same pixel order the video shifter consumes.
- Hands each completed long to the cog through a valid/get handshake.
- Optional pin-edge trigger and start delay, for aligning capture to sync.

Parameters:
- SYNC_STAGES, 2, number of input synchronizer flops on pin_in (minimum 2).

Ports:
- clk_cog  in  1  cog clock; the only clock.
- ena  in  1  asynchronous active-low reset (cog enable).
- setcfg  in  1  load cfg from data.
- setscl  in  1  load scl from data[19:0].
- getpix  in  1  cog consumes the held long.
- data  in  32  configuration value.
- pin_in  in  32  raw pin inputs (asynchronous).
- pixels  out  32  captured long.
- valid  out  1  pixels holds an unconsumed long.
- ovr  out  1  sticky overrun flag.
- active  out  1  capture in progress.

Behaviour:
- **Reset** (ena low, asynchronous):
  - cfg, scl, shift register, counters, pixels, valid and ovr all go to 0.
  - State goes to IDLE.
  - Synchronizer flops also go to 0.
- **cfg fields:**
  - [31] enable
  - [28] mode (0 = 1bpp, 1 = 2bpp)
  - [24] trigger enable
  - [23] trigger edge (1 = rising, 0 = falling)
  - [22:18] trigger pin
  - [4:0] data pin `sel`
- **scl fields:**
  - [19:12] cpp, clocks per pixel; 0 means 256.
  - [11:0] delay, in clocks; 0 means none.
- **Sampling source:**
  - All pin reads use the synchronized pins `ps`, which are pin_in delayed by SYNC_STAGES clocks.
  - 1bpp sample = ps[sel].
  - 2bpp sample = {ps[sel+1 mod 32], ps[sel]}.
- **setcfg:**
  - Loads cfg.
  - Clears valid, ovr, shift register and pixel count.
  - Next state: enable=0 gives IDLE; otherwise trigger enable gives ARM, delay≠0 gives DELAY, else CAPTURE.
  - Wins over a simultaneous getpix.
- **setscl:**
  - Loads scl with no state change.
  - The new cpp/delay take effect at the next counter reload.
  - If setscl coincides with setcfg, the new values are used for that setcfg.
- **States:**
  - IDLE: nothing happens; active=0.
  - ARM: trig_prev tracks ps[trigpin] each clock. On the selected edge (trig_prev→ps), go to DELAY with dcnt=delay, or to CAPTURE if delay=0.
  - DELAY: dcnt decrements each clock. At dcnt==1, go to CAPTURE.
  - CAPTURE entry: cnt=cpp, pcount=0.
- **CAPTURE, each clock:**
  - cnt decrements.
  - When cnt==1:
    - Sample into the shift register: 1bpp {s, sh[31:1]}; 2bpp {s, sh[31:2]}.
    - Reload cnt=cpp.
    - Increment pcount.
  - The first sample is taken cpp clocks after entry.
- **Word completion:**
  - Occurs at the sample with pcount=31 (1bpp) or 15 (2bpp); pcount then wraps to 0.
  - Capture continues with no gap.
  - The completed word is the post-shift value.
- **Handoff:**
  - If valid=0, or getpix is asserted the same cycle: pixels<=word and valid<=1.
  - Otherwise the word is dropped, ovr<=1 (sticky until setcfg or reset), and pixels is unchanged.
- **getpix:**
  - Clears valid next cycle unless a word loads in the same cycle.
  - With valid=0 it has no effect.
- **Outputs:** all registered; active = (state==CAPTURE).
- **Disabling:** setcfg with enable=0 mid-word discards the partial word; pixels retains its last value.

Decomposition:
- Package cog_vcap_pkg holds:
  - state enum {IDLE, ARM, DELAY, CAPTURE};
  - cfg/scl bit-position constants.
- Sub-module cog_vcap_sync: SYNC_STAGES-deep 32-bit synchronizer, reset by ena.

Test Plan:
- **Reset:** pulse ena low mid-capture → pixels=0, valid=0, ovr=0, active=0 immediately; they remain 0 after release until setcfg.
- **1bpp:** cpp=4, delay=0, no trigger, sel=5; pin_in[5] changes every 4 clocks so that sample k = k&1.
  - Expected: valid rises after 128 clocks of CAPTURE.
  - Expected: pixels=0xAAAAAAAA.
- **2bpp wrap:** sel=31, pin31=1, pin0=0 held → after 16×cpp clocks pixels=0x55555555.
- **Trigger:** rising edge, trigger pin=7, delay=10.
  - No activity while pin7 stays low.
  - active asserts 10 clocks after the edge is seen on ps[7].
  - A falling edge alone does not trigger.
- **Overrun:** no getpix across two words → ovr=1, pixels holds word 1.
  - Then getpix coincident with a completion → the new word loads, valid stays 1.
  - setcfg clears ovr.
- **cpp=0:** each sample is spaced 256 clocks; pcount and valid timing follow (1bpp word every 8192 clocks).
